mpsoc_ahb4_ext_responder: RTL

AHB4-Lite slave that answers the external AHB4 port of the mpsoc2d_riscv system, which is the initiator on that port. It is used in system benches and FPGA top levels as a local memory behind that port. It holds a word-addressed RAM and supports configurable wait states, little-endian byte/halfword/word lanes, and the two-cycle AHB ERROR response for illegal accesses.

---
 rtl/mpsoc_ahb4_ext_responder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mpsoc_ahb4_ext_responder.sv
// AHB4-Lite memory responder for the external AHB4 port of mpsoc2d_riscv.
// Word-addressed RAM with configurable wait states, little-endian byte and
// halfword lanes, and the two-cycle ERROR response for illegal accesses.
module mpsoc_ahb4_ext_responder #(
  parameter int unsigned     PLEN        = 32,
  parameter int unsigned     XLEN        = 32,
  parameter logic [PLEN-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned     MEM_WORDS   = 1024,
  parameter int unsigned     WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ahb4_hsel_i,
  input  logic [PLEN-1:0] ahb4_haddr_i,
  input  logic [XLEN-1:0] ahb4_hwdata_i,
  input  logic            ahb4_hwrite_i,
  input  logic [2:0]      ahb4_hsize_i,
  input  logic [2:0]      ahb4_hburst_i,
  input  logic [3:0]      ahb4_hprot_i,
  input  logic [1:0]      ahb4_htrans_i,
  input  logic            ahb4_hmastlock_i,
  input  logic            ahb4_hready_i,
  output logic [XLEN-1:0] ahb4_hrdata_o,
  output logic            ahb4_hready_o,
  output logic            ahb4_hresp_o
);

  localparam int unsigned     IDXW      = $clog2(MEM_WORDS);
  localparam logic [PLEN-1:0] MEM_BYTES = PLEN'(4 * MEM_WORDS);
  localparam logic [3:0]      WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit              HAS_WAIT  = (WAIT_STATES > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Registered address phase (the access whose data phase is in progress)
  logic            dp_valid_q, dp_valid_d;
  logic            dp_legal_q, dp_legal_d;
  logic            dp_write_q, dp_write_d;
  logic [1:0]      dp_size_q,  dp_size_d;
  logic [1:0]      dp_lane_q,  dp_lane_d;
  logic [IDXW-1:0] dp_idx_q,   dp_idx_d;

  logic [XLEN-1:0] mem [MEM_WORDS];

  logic [PLEN-1:0] offset;
  logic            in_range;
  logic            aligned;
  logic            req_legal;
  logic            accept;
  logic [3:0]      byte_en;
  logic            wr_en;

  logic unused_inputs;
  assign unused_inputs = ^{ahb4_hburst_i, ahb4_hprot_i, ahb4_hmastlock_i, ahb4_htrans_i[0]};

  // Address-phase decode: range, size and alignment legality
  always_comb begin
    offset   = ahb4_haddr_i - BASE_ADDR;
    in_range = (ahb4_haddr_i >= BASE_ADDR) && (offset < MEM_BYTES);
    case (ahb4_hsize_i)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = ~ahb4_haddr_i[0];
      3'd2:    aligned = (ahb4_haddr_i[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    req_legal = in_range && aligned;
    // Address phases are only taken while this slave is itself ready
    accept    = ahb4_hsel_i & ahb4_hready_i & ahb4_htrans_i[1] & ahb4_hready_o;
  end

  // FSM state and wait counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (!req_legal) begin
            state_d = ST_ERR1;
          end else if (HAS_WAIT) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: HREADY/HRESP are pure functions of state
  always_comb begin
    ahb4_hready_o = 1'b1;
    ahb4_hresp_o  = 1'b0;
    case (state_q)
      ST_WAIT: ahb4_hready_o = 1'b0;
      ST_ERR1: begin
        ahb4_hready_o = 1'b0;
        ahb4_hresp_o  = 1'b1;
      end
      ST_ERR2: ahb4_hresp_o = 1'b1;
      default: ;
    endcase
  end

  // Data-phase registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid_q <= 1'b0;
      dp_legal_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_size_q  <= '0;
      dp_lane_q  <= '0;
      dp_idx_q   <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_legal_q <= dp_legal_d;
      dp_write_q <= dp_write_d;
      dp_size_q  <= dp_size_d;
      dp_lane_q  <= dp_lane_d;
      dp_idx_q   <= dp_idx_d;
    end
  end

  // Capture a new address phase whenever the current data phase completes
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_legal_d = dp_legal_q;
    dp_write_d = dp_write_q;
    dp_size_d  = dp_size_q;
    dp_lane_d  = dp_lane_q;
    dp_idx_d   = dp_idx_q;
    if (ahb4_hready_o) begin
      dp_valid_d = accept;
      if (accept) begin
        dp_legal_d = req_legal;
        dp_write_d = ahb4_hwrite_i;
        dp_size_d  = ahb4_hsize_i[1:0];
        dp_lane_d  = ahb4_haddr_i[1:0];
        dp_idx_d   = offset[IDXW+1:2];
      end
    end
  end

  // Little-endian byte enables and write strobe for the completing data phase
  always_comb begin
    case (dp_size_q)
      2'd0:    byte_en = 4'b0001 << dp_lane_q;
      2'd1:    byte_en = dp_lane_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
    wr_en = dp_valid_q & dp_legal_q & dp_write_q & ahb4_hready_o;
  end

  // RAM write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[dp_idx_q][8*i +: 8] <= ahb4_hwdata_i[8*i +: 8];
        end
      end
    end
  end

  // Read data: a write in the previous data phase has already been committed,
  // so an overlapping read sees the new word without any forwarding path.
  always_comb begin
    ahb4_hrdata_o = '0;
    if (dp_valid_q && dp_legal_q && !dp_write_q && ahb4_hready_o) begin
      ahb4_hrdata_o = mem[dp_idx_q];
    end
  end

endmodule
